// File: rtl/data_mem_resp_if.sv
// MEM-stage data-memory bus: pipeline request side and memory response side.
interface data_mem_resp_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Stall;
  logic        Err;

  modport master (
    output MemRead, MemWrite, Addr, WriteData,
    input  ReadData, Stall, Err
  );

  modport slave (
    input  MemRead, MemWrite, Addr, WriteData,
    output ReadData, Stall, Err
  );
endinterface

// File: rtl/data_mem_resp.sv
// Multi-cycle word-addressed data memory with a pipeline stall handshake.
// Each access stalls for the acceptance cycle plus LATENCY busy cycles, then a one-cycle DONE.
module data_mem_resp #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned LATENCY = 2
) (
  input  logic           clk,
  input  logic           rst,
  data_mem_resp_if.slave bus
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic                op_wr;
  logic [ADDR_W-1:0]   idx;
  logic [31:0]         wdata;
  logic [31:0]         rdata_q;
  logic                err_q;
  logic [31:0]         mem [DEPTH];

  logic req, aligned, dual, accept, last;
  logic unused_addr_bits;

  assign req     = bus.MemRead | bus.MemWrite;
  assign aligned = (bus.Addr[1:0] == 2'b00);
  assign dual    = bus.MemRead & bus.MemWrite;
  assign accept  = (state == IDLE) && req && aligned;
  assign last    = (state == BUSY) && (cnt == '0);

  // Upper address bits alias onto the array, so addresses wrap.
  assign unused_addr_bits = ^bus.Addr[31:ADDR_W+2];

  assign bus.Stall    = !rst && (accept || (state == BUSY));
  assign bus.ReadData = rdata_q;
  assign bus.Err      = err_q;

  // Control FSM, load data and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req && (!aligned || dual)) err_q <= 1'b1;
          if (accept) begin
            state <= BUSY;
            cnt   <= CNT_LOAD;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            state <= DONE;
            if (!op_wr) rdata_q <= mem[idx];
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Request capture; a dual request falls through as a write.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_wr <= bus.MemWrite;
      idx   <= bus.Addr[ADDR_W+1:2];
      wdata <= bus.WriteData;
    end
  end

  // Storage array is never reset; a reset mid-access drops the pending write.
  always_ff @(posedge clk) begin
    if (!rst && last && op_wr) mem[idx] <= wdata;
  end

endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, the word-address width, giving 2^ADDR_W 32-bit words.
REQ-002 The block SHALL have parameter LATENCY, default 2, the BUSY cycles per access; legal range 1..15.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port MemRead, input, 1 bit: MEM-stage read request.
REQ-006 The block SHALL have port MemWrite, input, 1 bit: MEM-stage write request.
REQ-007 The block SHALL have port Addr, input, 32 bits: byte address; word index is Addr[ADDR_W+1:2].
REQ-008 The block SHALL have port WriteData, input, 32 bits: store data.
REQ-009 The block SHALL have port ReadData, output, 32 bits: registered load data.
REQ-010 The block SHALL have port Stall, output, 1 bit: pipeline freeze request.
REQ-011 The block SHALL have port Err, output, 1 bit: sticky protocol-error flag.

Function
REQ-012 The block SHALL implement an FSM with states IDLE, BUSY and DONE, plus a 4-bit down-counter cnt.
REQ-013 In IDLE, a request (MemRead|MemWrite) with Addr[1:0]==0 SHALL be accepted: latch op, word index and WriteData; load cnt=LATENCY-1; go to BUSY.
REQ-014 Stall SHALL be combinational: 1 in IDLE while a valid request is present, 1 throughout BUSY, and 0 in DONE and otherwise.
REQ-015 The stall window per access SHALL be exactly LATENCY+1 cycles: the acceptance cycle plus LATENCY BUSY cycles.
REQ-016 In BUSY, cnt SHALL decrement each cycle; when cnt==0, the FSM SHALL go to DONE on that edge.
REQ-017 On the BUSY->DONE edge, a read SHALL load ReadData from mem[index], and a write SHALL commit mem[index]<=latched WriteData.
REQ-018 ReadData SHALL hold its value until the next read completes; writes SHALL NOT alter ReadData.
REQ-019 DONE SHALL last one cycle and return to IDLE; request inputs seen in DONE SHALL be ignored, because the pipeline advances at that edge.
REQ-020 Request inputs SHALL be sampled only at acceptance; changes during BUSY SHALL have no effect.
REQ-021 MemRead and MemWrite both high in IDLE SHALL set Err and be treated as a write; the access SHALL still proceed.
REQ-022 A request with Addr[1:0]!=0 in IDLE SHALL set Err, SHALL NOT be accepted, SHALL NOT assert Stall, and SHALL NOT access the array.
REQ-023 Err SHALL remain set until reset.
REQ-024 Addr bits above ADDR_W+1 SHALL be ignored, so addresses wrap modulo 2^(ADDR_W+2) bytes.
REQ-025 Back-to-back requests SHALL be separated by at least the DONE cycle; the next acceptance SHALL occur no earlier than the cycle after DONE.

Reset
REQ-026 With rst high at an edge, the block SHALL set state=IDLE, cnt=0, ReadData=0 and Err=0; Stall SHALL read 0 while rst is high.
REQ-027 Reset during BUSY SHALL abort the access: a pending write SHALL be discarded, and memory contents SHALL NOT be cleared or modified by reset.
REQ-028 A request present on the edge where rst falls SHALL be evaluated normally in the following cycle.

Verification
REQ-029 Write then read: write Addr=0x10, WriteData=0xDEADBEEF (held until Stall falls), then read Addr=0x10 -> each access stalls exactly 3 cycles; ReadData=0xDEADBEEF in the read's DONE cycle.
REQ-030 Misaligned access: MemRead with Addr=0x13 -> Stall stays 0, Err=1 the next cycle, ReadData unchanged.
REQ-031 Dual request: MemRead=MemWrite=1, Addr=0x20, WriteData=0x5 -> Err=1; a subsequent read of 0x20 returns 0x5.
REQ-032 Reset mid-write: write 0x0 to Addr=0x40 (previously 0x1234), assert rst in the second BUSY cycle -> Stall=0, state IDLE; a read of 0x40 returns 0x1234.
REQ-033 Wrap-around: with ADDR_W=8, write 0xA5 to Addr=0x400 -> a read of Addr=0x000 returns 0xA5.
REQ-034 LATENCY=1 build: a read stalls exactly 2 cycles; back-to-back reads accept on the cycle after DONE.
